calendar_date_counter: RTL

Sequential calendar register that sits directly upstream of `day_of_week`: it holds the current date as day/month/year and advances it by one day per `tick`. It accepts externally loaded dates through a valid/ready handshake and range-checks them, including leap-year February. Its `day`, `month` and `year` outputs are width-compatible with `day_of_week` and drive it directly.

---
 rtl/calendar_pkg.sv | 32 +++
 rtl/calendar_date_counter_if.sv | 38 +++
 rtl/days_in_month.sv | 25 ++
 rtl/calendar_date_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
//------------------------------------------------------------------------------
// Module   : calendar_pkg
// Purpose  : Shared widths, month-length table, FSM states and leap-year rule.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package calendar_pkg;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 13;

    // Indexed directly by month; out-of-range months map to 0 so no day validates.
    localparam logic [DAY_W-1:0] MONTH_DAYS [0:15] = '{
        5'd0,  5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31,
        5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd0,  5'd0,  5'd0
    };

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return ((y % 13'd400) == 13'd0) ||
               (((y % 13'd4) == 13'd0) && ((y % 13'd100) != 13'd0));
    endfunction

endpackage

`default_nettype wire

// File: rtl/calendar_date_counter_if.sv
//------------------------------------------------------------------------------
// Module   : calendar_date_counter_if
// Purpose  : Date-load valid/ready channel (load_dow under CALENDAR_DATE_COUNTER_DOW_EN).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface calendar_date_counter_if;
    import calendar_pkg::*;

    logic               load_valid;
    logic               load_ready;
    logic [DAY_W-1:0]   load_day;
    logic [MONTH_W-1:0] load_month;
    logic [YEAR_W-1:0]  load_year;
`ifdef CALENDAR_DATE_COUNTER_DOW_EN
    logic [2:0]         load_dow;
`endif

    modport master (
`ifdef CALENDAR_DATE_COUNTER_DOW_EN
        output load_dow,
`endif
        output load_valid, load_day, load_month, load_year,
        input  load_ready
    );

    modport slave (
`ifdef CALENDAR_DATE_COUNTER_DOW_EN
        input  load_dow,
`endif
        input  load_valid, load_day, load_month, load_year,
        output load_ready
    );

endinterface

`default_nettype wire

// File: rtl/days_in_month.sv
//------------------------------------------------------------------------------
// Module   : days_in_month
// Purpose  : Combinational month length for a (month, year) pair, leap-aware.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module days_in_month
    import calendar_pkg::*;
(
    input  wire [MONTH_W-1:0] month,
    input  wire [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]  days
);

    always_comb begin
        days = MONTH_DAYS[month];
        if ((month == 4'd2) && is_leap(year)) begin
            days = 5'd29;
        end
    end

endmodule

`default_nettype wire

// File: rtl/calendar_date_counter.sv
//------------------------------------------------------------------------------
// Module   : calendar_date_counter
// Purpose  : Day/month/year register advanced by tick, with range-checked loads.
//            Weekday tracking is built when CALENDAR_DATE_COUNTER_DOW_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_MAX = 9999
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   tick,
    calendar_date_counter_if.slave ld,
    output logic [DAY_W-1:0]      day,
    output logic [MONTH_W-1:0]    month,
    output logic [YEAR_W-1:0]     year,
    output logic                  date_valid,
    output logic                  load_error,
    output logic                  wrap
`ifdef CALENDAR_DATE_COUNTER_DOW_EN
    ,
    output logic [2:0]            dow
`endif
);

    // The year field tops out at 2**YEAR_W-1; a larger YEAR_MAX is clamped so year+1 never overflows.
    localparam logic [YEAR_W-1:0] c_year_last =
        (YEAR_MAX > (2**YEAR_W - 1)) ? YEAR_W'(2**YEAR_W - 1) : YEAR_W'(YEAR_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_load_ready;
    logic [DAY_W-1:0]   r_stage_day;
    logic [MONTH_W-1:0] r_stage_month;
    logic [YEAR_W-1:0]  r_stage_year;
    logic [DAY_W-1:0]   w_cur_dim;
    logic [DAY_W-1:0]   w_stage_dim;
    logic               w_stage_legal;
    logic               w_accept;
    logic               w_advance;
    logic               w_commit;
    logic               w_reject;
    logic [DAY_W-1:0]   w_inc_day;
    logic [MONTH_W-1:0] w_inc_month;
    logic [YEAR_W-1:0]  w_inc_year;
    logic               w_inc_wrap;
`ifdef CALENDAR_DATE_COUNTER_DOW_EN
    logic [2:0]         r_stage_dow;
`endif

    assign ld.load_ready = r_load_ready;

    days_in_month u_dim_cur (
        .month (month),
        .year  (year),
        .days  (w_cur_dim)
    );

    days_in_month u_dim_stage (
        .month (r_stage_month),
        .year  (r_stage_year),
        .days  (w_stage_dim)
    );

    always_comb begin
        w_stage_legal = (r_stage_month >= 4'd1) && (r_stage_month <= 4'd12) &&
                        (r_stage_day >= 5'd1)   && (r_stage_day <= w_stage_dim) &&
                        (r_stage_year >= 13'd1) && (r_stage_year <= c_year_last);
`ifdef CALENDAR_DATE_COUNTER_DOW_EN
        if (r_stage_dow == 3'd7) begin
            w_stage_legal = 1'b0;
        end
`endif
    end

    always_comb begin
        w_inc_day   = day + 5'd1;
        w_inc_month = month;
        w_inc_year  = year;
        w_inc_wrap  = 1'b0;
        if (day >= w_cur_dim) begin
            w_inc_day = 5'd1;
            if (month < 4'd12) begin
                w_inc_month = month + 4'd1;
            end else if (year < c_year_last) begin
                w_inc_month = 4'd1;
                w_inc_year  = year + 13'd1;
            end else begin
                w_inc_month = 4'd1;
                w_inc_year  = 13'd1;
                w_inc_wrap  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load accept takes priority over a tick in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_commit    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ld.load_valid && r_load_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_CHECK;
                end else if (tick) begin
                    w_advance = 1'b1;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_RUN;
                w_commit    = w_stage_legal;
                w_reject    = !w_stage_legal;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day           <= 5'd1;
            month         <= 4'd1;
            year          <= 13'd1;
            date_valid    <= 1'b1;
            r_load_ready  <= 1'b1;
            load_error    <= 1'b0;
            wrap          <= 1'b0;
            r_stage_day   <= '0;
            r_stage_month <= '0;
            r_stage_year  <= '0;
        end else begin
            date_valid   <= (w_state_nxt == ST_RUN);
            r_load_ready <= (w_state_nxt == ST_RUN);
            load_error   <= w_reject;
            wrap         <= w_advance && w_inc_wrap;
            if (w_accept) begin
                r_stage_day   <= ld.load_day;
                r_stage_month <= ld.load_month;
                r_stage_year  <= ld.load_year;
            end
            if (w_commit) begin
                day   <= r_stage_day;
                month <= r_stage_month;
                year  <= r_stage_year;
            end else if (w_advance) begin
                day   <= w_inc_day;
                month <= w_inc_month;
                year  <= w_inc_year;
            end
        end
    end

`ifdef CALENDAR_DATE_COUNTER_DOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dow         <= 3'd1;
            r_stage_dow <= 3'd0;
        end else begin
            if (w_accept) begin
                r_stage_dow <= ld.load_dow;
            end
            if (w_commit) begin
                dow <= r_stage_dow;
            end else if (w_advance) begin
                if (w_inc_wrap) begin
                    dow <= 3'd1;
                end else if (dow >= 3'd6) begin
                    dow <= 3'd0;
                end else begin
                    dow <= dow + 3'd1;
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire
